if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from PC+4, branch target or jump target.
- Registers the IF/ID latch consumed by the decode stage: register file read, sign extension of instr[15:0], control.
- Detects the HALT instruction and freezes fetch so the debug unit can observe pipeline drain.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 47 ++++
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, special instructions and
// instruction field positions used by every stage of the MIPS pipeline.
package pipeline_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [5:0]  HALT_OPCODE = 6'b111111;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          PC_INC      = 4;

  // Field positions shared by opcode decode and the immediate sign-extender
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline latch between two stages with hold (stall) and flush (bubble)
// controls; hold takes priority over flush.
module if_id_reg #(
  parameter int                    PC_SIZE    = 32,
  parameter int                    INSTR_SIZE = 32,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_hold,
  input  logic                  i_flush,
  input  logic [INSTR_SIZE-1:0] i_instr,
  input  logic [PC_SIZE-1:0]    i_pc_plus4,
  output logic [INSTR_SIZE-1:0] o_instr,
  output logic [PC_SIZE-1:0]    o_pc_plus4,
  output logic                  o_valid
);

  logic [INSTR_SIZE-1:0] instr_p1;
  logic [PC_SIZE-1:0]    pc_plus4_p1;
  logic                  vld_p1;

  // Stage boundary: fetch -> decode
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      instr_p1    <= NOP_INSTR;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (i_enable && !i_hold) begin
      if (i_flush) begin
        instr_p1    <= NOP_INSTR;
        pc_plus4_p1 <= '0;
        vld_p1      <= 1'b0;
      end else begin
        instr_p1    <= i_instr;
        pc_plus4_p1 <= i_pc_plus4;
        vld_p1      <= 1'b1;
      end
    end
  end

  assign o_instr    = instr_p1;
  assign o_pc_plus4 = pc_plus4_p1;
  assign o_valid    = vld_p1;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, HALT detection
// with a RUN/HALTED freeze FSM, and the IF/ID latch feeding decode.
module if_stage #(
  parameter int                    PC_SIZE     = 32,
  parameter int                    INSTR_SIZE  = 32,
  parameter logic [5:0]            HALT_OPCODE = pipeline_pkg::HALT_OPCODE,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR   = pipeline_pkg::NOP_INSTR
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [PC_SIZE-1:0]    i_branch_target,
  input  logic                  i_jump,
  input  logic [PC_SIZE-1:0]    i_jump_target,
  input  logic [INSTR_SIZE-1:0] i_instr,
  output logic [PC_SIZE-1:0]    o_pc,
  output logic [INSTR_SIZE-1:0] o_instr,
  output logic [PC_SIZE-1:0]    o_pc_plus4,
  output logic                  o_valid,
  output logic                  o_halt
);

  import pipeline_pkg::*;

  fetch_state_t       state_p0;
  logic [PC_SIZE-1:0] pc_p0;
  logic [PC_SIZE-1:0] pc_inc;
  logic               halt_p0;
  logic               halt_fetch;
  logic               id_flush;

  assign pc_inc     = pc_p0 + PC_SIZE'(PC_INC);
  assign halt_fetch = (i_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  // A redirect squashes whatever was fetched this cycle, including a HALT
  assign id_flush   = (state_p0 == ST_HALTED) || i_jump || i_branch_taken;

  // Stage boundary: PC and fetch FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_p0 <= ST_RUN;
      pc_p0    <= '0;
      halt_p0  <= 1'b0;
    end else if (i_enable) begin
      case (state_p0)
        ST_RUN: begin
          if (!i_stall) begin
            if (i_jump) begin
              pc_p0 <= i_jump_target;
            end else if (i_branch_taken) begin
              pc_p0 <= i_branch_target;
            end else if (halt_fetch) begin
              state_p0 <= ST_HALTED;
              halt_p0  <= 1'b1;
            end else begin
              pc_p0 <= pc_inc;
            end
          end
        end
        ST_HALTED: begin
          state_p0 <= ST_HALTED;
        end
        default: begin
          state_p0 <= ST_RUN;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_SIZE    (PC_SIZE),
    .INSTR_SIZE (INSTR_SIZE),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_hold     (i_stall),
    .i_flush    (id_flush),
    .i_instr    (i_instr),
    .i_pc_plus4 (pc_inc),
    .o_instr    (o_instr),
    .o_pc_plus4 (o_pc_plus4),
    .o_valid    (o_valid)
  );

  assign o_pc   = pc_p0;
  assign o_halt = halt_p0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural fetch model checked every cycle,
// plus hand-computed expectations along the directed sequence.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;
  logic [31:0] instr;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [31:0] o_pc_plus4;
  logic        o_valid;
  logic        o_halt;

  int total;
  int bad;
  logic chk_on;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_vld;
  logic        m_halt;

  if_stage dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (bt),
    .i_jump          (jmp),
    .i_jump_target   (jt),
    .i_instr         (instr),
    .o_pc            (o_pc),
    .o_instr         (o_instr),
    .o_pc_plus4      (o_pc_plus4),
    .o_valid         (o_valid),
    .o_halt          (o_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a halted fetch unit only emits bubbles; a running one follows the
  // stall > jump > branch > halt > sequential priority.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'd0;
      m_instr <= 32'd0;
      m_pp4   <= 32'd0;
      m_vld   <= 1'b0;
      m_halt  <= 1'b0;
    end else if (en && !stall) begin
      if (m_halt || jmp || br) begin
        m_instr <= 32'd0;
        m_vld   <= 1'b0;
      end else begin
        m_instr <= instr;
        m_pp4   <= m_pc + 32'd4;
        m_vld   <= 1'b1;
      end
      if (!m_halt) begin
        if (jmp)
          m_pc <= jt;
        else if (br)
          m_pc <= bt;
        else if (instr[31:26] == 6'b111111)
          m_halt <= 1'b1;
        else
          m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_pc", o_pc, m_pc);
      cmp("model_instr", o_instr, m_instr);
      cmp("model_valid", {31'd0, o_valid}, {31'd0, m_vld});
      cmp("model_halt", {31'd0, o_halt}, {31'd0, m_halt});
      if (m_vld)
        cmp("model_pc_plus4", o_pc_plus4, m_pp4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_on = 1'b0;
    rst    = 1'b0;
    en     = 1'b1;
    stall  = 1'b0;
    br     = 1'b0;
    jmp    = 1'b0;
    bt     = 32'd0;
    jt     = 32'd0;
    instr  = 32'h2001_0005;

    #1 rst = 1'b1;
    #1;
    cmp("reset_pc", o_pc, 32'd0);
    cmp("reset_instr", o_instr, 32'd0);
    cmp("reset_pc_plus4", o_pc_plus4, 32'd0);
    cmp("reset_valid", {31'd0, o_valid}, 32'd0);
    cmp("reset_halt", {31'd0, o_halt}, 32'd0);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Sequential fetch
    step();
    cmp("seq1_pc", o_pc, 32'd4);
    cmp("seq1_instr", o_instr, 32'h2001_0005);
    cmp("seq1_pc_plus4", o_pc_plus4, 32'd4);
    cmp("seq1_valid", {31'd0, o_valid}, 32'd1);
    step();
    cmp("seq2_pc", o_pc, 32'd8);
    cmp("seq2_pc_plus4", o_pc_plus4, 32'd8);

    // Stall at PC 8, with a redirect present that must be ignored
    stall = 1'b1;
    br    = 1'b1;
    bt    = 32'h0000_0500;
    for (int i = 0; i < 2; i++) begin
      step();
      cmp("stall_pc", o_pc, 32'd8);
      cmp("stall_pc_plus4", o_pc_plus4, 32'd8);
      cmp("stall_instr", o_instr, 32'h2001_0005);
    end
    stall = 1'b0;
    br    = 1'b0;
    step();
    cmp("resume_pc", o_pc, 32'd12);
    cmp("resume_pc_plus4", o_pc_plus4, 32'd12);
    step();
    cmp("seq_pc16", o_pc, 32'd16);

    // Branch taken
    br = 1'b1;
    bt = 32'h0000_0040;
    step();
    cmp("branch_pc", o_pc, 32'h0000_0040);
    cmp("branch_instr", o_instr, 32'd0);
    cmp("branch_valid", {31'd0, o_valid}, 32'd0);
    br  = 1'b0;
    jmp = 1'b1;
    jt  = 32'd16;
    step();
    cmp("jump16_pc", o_pc, 32'd16);

    // Jump and branch together: jump wins
    br = 1'b1;
    bt = 32'h0000_0040;
    jt = 32'h0000_0080;
    step();
    cmp("jump_wins_pc", o_pc, 32'h0000_0080);
    cmp("jump_wins_valid", {31'd0, o_valid}, 32'd0);
    br = 1'b0;
    jt = 32'd20;
    step();
    cmp("jump20_pc", o_pc, 32'd20);
    jmp = 1'b0;

    // HALT at PC 20
    instr = 32'hFC00_0000;
    step();
    cmp("halt_pc", o_pc, 32'd20);
    cmp("halt_instr", o_instr, 32'hFC00_0000);
    cmp("halt_flag", {31'd0, o_halt}, 32'd1);
    cmp("halt_valid", {31'd0, o_valid}, 32'd1);
    cmp("halt_pc_plus4", o_pc_plus4, 32'd24);
    stall = 1'b1;
    step();
    cmp("halted_stall_instr", o_instr, 32'hFC00_0000);
    cmp("halted_stall_valid", {31'd0, o_valid}, 32'd1);
    stall = 1'b0;
    br    = 1'b1;
    bt    = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      step();
      cmp("halted_flag", {31'd0, o_halt}, 32'd1);
      cmp("halted_pc", o_pc, 32'd20);
      cmp("halted_valid", {31'd0, o_valid}, 32'd0);
    end
    br = 1'b0;

    // Async reset pulse between edges while HALTED
    #1 rst = 1'b1;
    #1;
    cmp("async_rst_pc", o_pc, 32'd0);
    cmp("async_rst_halt", {31'd0, o_halt}, 32'd0);
    cmp("async_rst_valid", {31'd0, o_valid}, 32'd0);
    cmp("async_rst_instr", o_instr, 32'd0);
    rst = 1'b0;

    // HALT on the wrong path of a branch is discarded
    instr = 32'hFC00_0000;
    br    = 1'b1;
    bt    = 32'h0000_0100;
    step();
    cmp("wrongpath_pc", o_pc, 32'h0000_0100);
    cmp("wrongpath_halt", {31'd0, o_halt}, 32'd0);
    cmp("wrongpath_valid", {31'd0, o_valid}, 32'd0);
    br    = 1'b0;
    instr = 32'h2001_0005;

    // PC wrap-around
    jmp = 1'b1;
    jt  = 32'hFFFF_FFFC;
    step();
    cmp("wrap_pre_pc", o_pc, 32'hFFFF_FFFC);
    jmp = 1'b0;
    step();
    cmp("wrap_pc", o_pc, 32'd0);
    cmp("wrap_pc_plus4", o_pc_plus4, 32'd0);
    cmp("wrap_valid", {31'd0, o_valid}, 32'd1);

    // Enable low freezes everything, even with a jump and a HALT presented
    en    = 1'b0;
    jmp   = 1'b1;
    jt    = 32'h0000_0300;
    instr = 32'hFC00_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("freeze_pc", o_pc, 32'd0);
      cmp("freeze_pc_plus4", o_pc_plus4, 32'd0);
      cmp("freeze_instr", o_instr, 32'h2001_0005);
      cmp("freeze_valid", {31'd0, o_valid}, 32'd1);
      cmp("freeze_halt", {31'd0, o_halt}, 32'd0);
    end
    en    = 1'b1;
    jmp   = 1'b0;
    instr = 32'h2001_0005;
    step();
    cmp("unfreeze_pc", o_pc, 32'd4);
    cmp("unfreeze_pc_plus4", o_pc_plus4, 32'd4);
    step();

    chk_on = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
